// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1 serializer with back-to-back frames.
// Define UART_TX_PARITY_EN for 8E1 framing (even parity bit between data and stop).
module uart_tx_buffered #(
  parameter int CLK_FREQ   = 25_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [7:0]                   i_data,
  input  logic                         i_valid,
  output logic                         o_ready,
  output logic                         o_tx,
  output logic                         o_busy,
  output logic                         o_done,
  output logic [$clog2(FIFO_DEPTH):0]  o_count
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int OCC_W        = PTR_W + 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [OCC_W-1:0] count_reg;
  logic             push, pop, fifo_nonempty;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] clk_cnt_reg, clk_cnt_next;
  logic [2:0]       bit_idx_reg, bit_idx_next;
  logic [7:0]       shift_reg, shift_next;
  logic             tx_reg, tx_next;
  logic             done_reg, done_next;
  logic             busy_reg;
  logic             bit_end;
`ifdef UART_TX_PARITY_EN
  logic             parity_reg;
`endif

  assign fifo_nonempty = (count_reg != '0);
  assign o_ready       = (count_reg != OCC_W'(FIFO_DEPTH));
  assign push          = i_valid && o_ready;
  assign bit_end       = (clk_cnt_reg == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr_reg] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + OCC_W'(1);
        2'b01:   count_reg <= count_reg - OCC_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Popped byte is captured straight from the buffer (registered read).
  always_ff @(posedge i_clk) begin
    if (pop) begin
      shift_reg  <= mem[rd_ptr_reg];
`ifdef UART_TX_PARITY_EN
      parity_reg <= ^mem[rd_ptr_reg];
`endif
    end else begin
      shift_reg  <= shift_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg   <= S_IDLE;
      clk_cnt_reg <= '0;
      bit_idx_reg <= '0;
      tx_reg      <= 1'b1;
      done_reg    <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      clk_cnt_reg <= clk_cnt_next;
      bit_idx_reg <= bit_idx_next;
      tx_reg      <= tx_next;
      done_reg    <= done_next;
      busy_reg    <= (state_reg != S_IDLE) || fifo_nonempty;
    end
  end

  // Line level is registered from the current state, so o_tx trails the FSM by one clock.
  always_comb begin
    state_next   = state_reg;
    clk_cnt_next = bit_end ? '0 : clk_cnt_reg + CNT_W'(1);
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    tx_next      = 1'b1;
    done_next    = 1'b0;
    pop          = 1'b0;
    case (state_reg)
      S_IDLE: begin
        clk_cnt_next = '0;
        if (fifo_nonempty) begin
          pop          = 1'b1;
          bit_idx_next = '0;
          state_next   = S_START;
        end
      end
      S_START: begin
        tx_next = 1'b0;
        if (bit_end) state_next = S_DATA;
      end
      S_DATA: begin
        tx_next = shift_reg[0];
        if (bit_end) begin
          shift_next   = {1'b0, shift_reg[7:1]};
          bit_idx_next = bit_idx_reg + 3'd1;
          if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = S_PARITY;
`else
            state_next = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        tx_next = parity_reg;
        if (bit_end) state_next = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          done_next = 1'b1;
          if (fifo_nonempty) begin
            pop          = 1'b1;
            bit_idx_next = '0;
            state_next   = S_START;
          end else begin
            state_next   = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign o_tx    = tx_reg;
  assign o_busy  = busy_reg;
  assign o_done  = done_reg;
  assign o_count = count_reg;

endmodule
